// File: rtl/demux_4b_1to8_dispatch_if.sv
// Handshake bundle between the dispatch FIFO and its upstream producer and
// downstream demux lanes. The dispatcher uses the slave modport.
interface demux_4b_1to8_dispatch_if #(
  parameter int DEPTH = 4
) ();
  logic                     istream_val;
  logic                     istream_rdy;
  logic [6:0]               istream_msg;
  logic [3:0]               out_in_;
  logic [2:0]               out_sel;
  logic [7:0]               out_val;
  logic [7:0]               out_rdy;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  istream_val, istream_msg, out_rdy,
    output istream_rdy, out_in_, out_sel, out_val, count
  );

  modport master (
    output istream_val, istream_msg, out_rdy,
    input  istream_rdy, out_in_, out_sel, out_val, count
  );
endinterface

// File: rtl/demux_4b_1to8_dispatch.sv
// Buffered feeder for the 4-bit 1-to-8 demux: FIFO of {sel,data}, retires head on out_rdy[sel].
// Optional same-cycle bypass when empty: define DEMUX_DISPATCH_BYPASS_EN.
module demux_4b_1to8_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  demux_4b_1to8_dispatch_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [6:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [6:0] head;
  logic       has_head;
  logic       rdy;
  logic       enq;
  logic       deq;
  logic       wr_en;
  logic       byp_show;
  logic       byp_take;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    has_head = (count_q != '0);
    // Reset gates ready combinationally so nothing is accepted while held.
    rdy      = reset && (count_q != CW'(DEPTH));
    enq      = bus.istream_val && rdy;
    deq      = has_head && bus.out_rdy[head[6:4]];
`ifdef DEMUX_DISPATCH_BYPASS_EN
    byp_show = !has_head && bus.istream_val && rdy;
    byp_take = byp_show && bus.out_rdy[bus.istream_msg[6:4]];
`else
    byp_show = 1'b0;
    byp_take = 1'b0;
`endif
    wr_en    = enq && !byp_take;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(deq);
  end

  always_comb begin
    bus.istream_rdy = rdy;
    bus.count       = count_q;
    bus.out_in_     = 4'h0;
    bus.out_sel     = 3'h0;
    bus.out_val     = 8'h00;
    if (has_head) begin
      bus.out_in_ = head[3:0];
      bus.out_sel = head[6:4];
      bus.out_val = 8'h01 << head[6:4];
    end else if (byp_show) begin
      bus.out_in_ = bus.istream_msg[3:0];
      bus.out_sel = bus.istream_msg[6:4];
      bus.out_val = 8'h01 << bus.istream_msg[6:4];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: an entry is only exposed once count covers it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.istream_msg;
  end
endmodule

// File: tb/tb_demux_4b_1to8_dispatch.sv
// Directed bench for demux_4b_1to8_dispatch with a queue scoreboard of
// accepted messages, checked in order as the DUT retires them.
module tb_demux_4b_1to8_dispatch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [6:0] sb[$];

  demux_4b_1to8_dispatch_if #(.DEPTH(DEPTH)) bus ();

  demux_4b_1to8_dispatch #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: at the falling edge record accepted input and check any
  // retiring head against the scoreboard, then advance past the rising edge.
  task automatic cyc();
    logic [6:0] e;
    @(negedge clk);
    if (bus.istream_val && bus.istream_rdy) sb.push_back(bus.istream_msg);
    if (bus.out_val != 8'h00 && bus.out_rdy[bus.out_sel]) begin
      if (sb.size() == 0) begin
        chk("retire_unexpected", {24'h0, bus.out_val}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("retire_data", {28'h0, bus.out_in_}, {28'h0, e[3:0]});
        chk("retire_sel",  {29'h0, bus.out_sel}, {29'h0, e[6:4]});
        chk("retire_val",  {24'h0, bus.out_val}, {24'h0, 8'h01 << e[6:4]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] m;
    bus.istream_val = 1'b1;
    bus.istream_msg = 7'h35;
    bus.out_rdy     = 8'h00;

    // Reset held with valid high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",   {31'h0, bus.istream_rdy}, 32'h0);
    chk("rst_val",   {24'h0, bus.out_val}, 32'h0);
    chk("rst_count", {29'h0, bus.count}, 32'h0);
    bus.istream_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", {31'h0, bus.istream_rdy}, 32'h1);

    // Single message 0x35
    bus.out_rdy     = 8'hFF;
    bus.istream_val = 1'b1;
    bus.istream_msg = 7'h35;
    cyc();
    bus.istream_val = 1'b0;
    chk("single_val",   {24'h0, bus.out_val}, 32'h08);
    chk("single_data",  {28'h0, bus.out_in_}, 32'h5);
    chk("single_sel",   {29'h0, bus.out_sel}, 32'h3);
    chk("single_count", {29'h0, bus.count}, 32'h1);
    cyc();
    chk("single_drained", {29'h0, bus.count}, 32'h0);
    chk("empty_val",  {24'h0, bus.out_val}, 32'h0);
    chk("empty_data", {28'h0, bus.out_in_}, 32'h0);
    chk("empty_sel",  {29'h0, bus.out_sel}, 32'h0);

    // Fill to full with consumers stalled
    bus.out_rdy = 8'h00;
    bus.istream_val = 1'b1;
    bus.istream_msg = 7'h01; cyc();
    bus.istream_msg = 7'h12; cyc();
    bus.istream_msg = 7'h23; cyc();
    bus.istream_msg = 7'h34; cyc();
    chk("full_count", {29'h0, bus.count}, 32'h4);
    chk("full_rdy",   {31'h0, bus.istream_rdy}, 32'h0);
    bus.istream_msg = 7'h44; cyc();
    chk("full_hold_count", {29'h0, bus.count}, 32'h4);
    bus.istream_val = 1'b0;
    chk("full_head_val", {24'h0, bus.out_val}, 32'h01);
    bus.out_rdy = 8'hFF;
    repeat (4) cyc();
    chk("full_drained", {29'h0, bus.count}, 32'h0);
    chk("full_sb_empty", sb.size(), 32'h0);

    // Stalled destination 5 ignores other ready bits
    bus.out_rdy = 8'hDF;
    bus.istream_val = 1'b1;
    bus.istream_msg = 7'h5A;
    cyc();
    bus.istream_val = 1'b0;
    repeat (3) cyc();
    chk("stall_val",   {24'h0, bus.out_val}, 32'h20);
    chk("stall_count", {29'h0, bus.count}, 32'h1);
    bus.out_rdy = 8'h20;
    cyc();
    chk("stall_retired", {29'h0, bus.count}, 32'h0);

    // Steady stream: one in, one out per cycle across pointer wrap
    bus.out_rdy = 8'hFF;
    bus.istream_val = 1'b1;
    bus.istream_msg = 7'($urandom_range(0, 127));
    cyc();
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      m = 7'($urandom_range(0, 127));
      bus.istream_msg = m;
      cyc();
      chk("stream_count", {29'h0, bus.count}, 32'h1);
    end
    bus.istream_val = 1'b0;
    cyc();
    chk("stream_drained", {29'h0, bus.count}, 32'h0);
    chk("stream_sb_empty", sb.size(), 32'h0);

    // Reset mid-operation discards buffered entries
    bus.out_rdy = 8'h00;
    bus.istream_val = 1'b1;
    bus.istream_msg = 7'h61; cyc();
    bus.istream_msg = 7'h72; cyc();
    bus.istream_msg = 7'h03; cyc();
    bus.istream_val = 1'b0;
    chk("mid_count", {29'h0, bus.count}, 32'h3);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", {29'h0, bus.count}, 32'h0);
    chk("mid_rst_val",   {24'h0, bus.out_val}, 32'h0);
    chk("mid_rst_rdy",   {31'h0, bus.istream_rdy}, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_rdy = 8'hFF;
    cyc();
    chk("mid_after_val",   {24'h0, bus.out_val}, 32'h0);
    chk("mid_after_count", {29'h0, bus.count}, 32'h0);

`ifdef DEMUX_DISPATCH_BYPASS_EN
    bus.out_rdy = 8'h80;
    bus.istream_val = 1'b1;
    bus.istream_msg = 7'h7F;
    #1;
    chk("byp_val", {24'h0, bus.out_val}, 32'h80);
    cyc();
    bus.istream_val = 1'b0;
    chk("byp_count", {29'h0, bus.count}, 32'h0);
    chk("byp_sb_empty", sb.size(), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
